layer1_conv_ctrl: RTL and testbench
===================================

// Module: layer1_conv_ctrl
// PURPOSE
// - Sequences the layer-1 8-channel dot-product datapath over a 3x3 valid convolution of an IMG_W x IMG_H, 3-channel image.
// - Per output pixel: issues 9 tap reads (input pixel + weight tap), accumulates the 8 datapath partial sums,
//   saturates them to signed 16 bit and writes one 128-bit output word through a valid/ready port.
// - Sits between the input/weight buffers, the 8-lane datapath and the layer-1 output buffer.
// PARAMETERS
// - IMG_W   8   input image width in pixels (>=3)
// - IMG_H   8   input image height in pixels (>=3)
// - ADDR_W  12  input and output buffer address width
// - ACC_W   20  per-lane accumulator width (signed, >=16)
// PORTS
// - clk        in   1       clock, rising edge
// - rst        in   1       asynchronous reset, active high
// - start      in   1       start a full-image pass; sampled only in IDLE
// - busy       out  1       high from the cycle after start is accepted until done
// - done       out  1       one-cycle pulse after the last output word is accepted
// - in_rd_en   out  1       input-buffer and weight-buffer read strobe
// - in_addr    out  ADDR_W  input pixel address = (row+ky)*IMG_W + (col+kx)
// - w_tap      out  4       weight tap index 0..8 = ky*3+kx, drives the 8 weight buffers
// - psum       in   128     datapath outputs, lane n at [16n+15:16n], signed, valid 1 cycle after in_rd_en
// - out_valid  out  1       output word valid
// - out_ready  in   1       output buffer accepts the word
// - out_addr   out  ADDR_W  output address = row*(IMG_W-2)+col
// - out_data   out  128     8 saturated signed 16-bit results, lane n at [16n+15:16n]
// BEHAVIOUR
// - Reset: state IDLE; busy, done, in_rd_en, out_valid = 0; in_addr, w_tap, out_addr, out_data = 0; row, col, tap counters and accumulators = 0.
// - States: IDLE -(start)-> FETCH -(tap 8 issued)-> DRAIN -> WRITE -(out_ready & last pixel)-> DONE -> IDLE;
//   WRITE -(out_ready & not last)-> FETCH, advancing col, wrapping col to 0 and incrementing row at col = IMG_W-3.
// - FETCH: 9 consecutive cycles with in_rd_en = 1; taps in order ky major, kx minor (tap 0..8).
// - Accumulate: psum lanes sign-extended to ACC_W and added in the cycle after each read; tap 0 reloads (overwrites) the accumulator.
// - DRAIN: 1 cycle with in_rd_en = 0 to absorb the final tap's product.
// - WRITE: out_data = per-lane saturation of accumulator to [-32768, 32767]; out_valid held with out_data/out_addr stable until out_ready.
// - Throughput: 11 cycles per output pixel when out_ready is high; (IMG_W-2)*(IMG_H-2) words per pass.
// - done: high for exactly 1 cycle (DONE state), busy falls in the same cycle; IDLE follows.
// - start while busy ignored; start held high in DONE is not accepted until IDLE.
// - Reset mid-operation: immediate return to IDLE, partial results discarded, no done pulse.
// - No reads issued in DRAIN, WRITE, DONE or IDLE; out_valid never asserted outside WRITE.
// CONFIGURATION
// - LAYER1_RELU_EN defined: ReLU applied after saturation (negative lane -> 0x0000).
// - LAYER1_RELU_EN undefined: saturated signed value passed through unchanged.
// TESTING
// - IMG_W=IMG_H=4, every psum lane = 3 each tap, out_ready=1 -> 4 words, each lane 27 (0x001B), addrs 0..3, done 44 cycles after busy rises.
// - Pixel 0 address check -> in_addr sequence 0,1,2,4,5,6,8,9,10 with w_tap 0..8; pixel 3 starts at in_addr 5.
// - psum lanes = 0x7FFF each tap -> out lane 0x7FFF; lanes = 0x8000 -> 0x8000 (0x0000 with LAYER1_RELU_EN).
// - out_ready low 5 cycles during WRITE -> out_valid held, out_data/out_addr stable, in_rd_en = 0 throughout.
// - rst pulsed during FETCH of pixel 2 -> all outputs 0 next edge, no done; new start gives correct full pass.
// - start pulsed while busy -> ignored, pass unchanged, exactly one done pulse.

Source files
------------

// File: rtl/layer1_conv_ctrl_if.sv
// Handshake/bus bundle for the layer-1 convolution controller.
// master: controller side (drives reads, status and the output word).
// slave : surrounding buffers/datapath side.
// Signals: start, busy, done, in_rd_en, in_addr, w_tap, psum,
//          out_valid, out_ready, out_addr, out_data.
interface layer1_conv_ctrl_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              start;
  logic              busy;
  logic              done;
  logic              in_rd_en;
  logic [ADDR_W-1:0] in_addr;
  logic [3:0]        w_tap;
  logic [127:0]      psum;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [127:0]      out_data;

  modport master (
    input  start, psum, out_ready,
    output busy, done, in_rd_en, in_addr, w_tap, out_valid, out_addr, out_data
  );

  modport slave (
    output start, psum, out_ready,
    input  busy, done, in_rd_en, in_addr, w_tap, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/layer1_conv_ctrl.sv
// Layer-1 3x3 valid-convolution sequencer for the 8-lane dot-product datapath.
// Per output pixel: 9 tap reads, accumulate 8 partial-sum lanes, saturate to
// signed 16 bit, write one 128-bit word over a valid/ready port.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active high
//   bus  - layer1_conv_ctrl_if.master (start/busy/done, tap reads, psum in,
//          output word handshake)
// Build option: define LAYER1_RELU_EN to clamp negative results to zero
// after saturation; otherwise the saturated signed value passes through.
module layer1_conv_ctrl #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned ACC_W  = 20
) (
  input  logic                clk,
  input  logic                rst,
  layer1_conv_ctrl_if.master  bus
);

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned OUT_W  = IMG_W - 2;

  localparam logic [3:0]             TAP_LAST = 4'd8;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [3:0]       tap_q, tap_d;
  logic [1:0]       kx_q, kx_d;
  logic [1:0]       ky_q, ky_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d;
  logic [3:0]        w_tap_q, w_tap_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [127:0]      out_data_q, out_data_d;

  // Delayed read strobe: psum for a read arrives one cycle later.
  logic rd_pend_q;
  logic first_pend_q;

  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] acc_d [LANES];
  logic signed [ACC_W-1:0] lane_ext;

  logic last_pix;

  // Saturate one accumulator lane to signed 16 bit (optionally ReLU).
  function automatic logic [LANE_W-1:0] sat_lane(input logic signed [ACC_W-1:0] a);
    logic [LANE_W-1:0] r;
    if (a > SAT_MAX) begin
      r = 16'h7FFF;
    end else if (a < SAT_MIN) begin
      r = 16'h8000;
    end else begin
      r = a[LANE_W-1:0];
    end
`ifdef LAYER1_RELU_EN
    if (r[LANE_W-1]) begin
      r = '0;
    end
`endif
    return r;
  endfunction

  assign last_pix = (row_q == ROW_W'(IMG_H - 3)) && (col_q == COL_W'(IMG_W - 3));

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          tap_d   = '0;
          kx_d    = '0;
          ky_d    = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_FETCH: begin
        if (tap_q == TAP_LAST) begin
          state_d = S_DRAIN;
        end else begin
          tap_d = tap_q + 4'd1;
          // ky major, kx minor
          if (kx_q == 2'd2) begin
            kx_d = '0;
            ky_d = ky_q + 2'd1;
          end else begin
            kx_d = kx_q + 2'd1;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus.out_ready) begin
          tap_d = '0;
          kx_d  = '0;
          ky_d  = '0;
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            if (col_q == COL_W'(IMG_W - 3)) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-lane accumulate; tap 0 product overwrites the previous pixel's sum.
  always_comb begin
    lane_ext = '0;
    for (int n = 0; n < LANES; n++) begin
      lane_ext = ACC_W'(signed'(bus.psum[LANE_W*n +: LANE_W]));
      acc_d[n] = acc_q[n];
      if (rd_pend_q) begin
        acc_d[n] = first_pend_q ? lane_ext : acc_q[n] + lane_ext;
      end
    end
  end

  // Registered outputs, derived from the upcoming state so they line up with it.
  always_comb begin
    busy_d      = (state_d == S_FETCH) || (state_d == S_DRAIN) || (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    rd_en_d     = (state_d == S_FETCH);
    out_valid_d = (state_d == S_WRITE);
    in_addr_d   = in_addr_q;
    w_tap_d     = w_tap_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (rd_en_d) begin
      in_addr_d = (ADDR_W'(row_d) + ADDR_W'(ky_d)) * ADDR_W'(IMG_W)
                + ADDR_W'(col_d) + ADDR_W'(kx_d);
      w_tap_d   = tap_d;
    end
    // The last product lands during DRAIN; capture the finished word then.
    if (state_q == S_DRAIN) begin
      out_addr_d = ADDR_W'(row_q) * ADDR_W'(OUT_W) + ADDR_W'(col_q);
      for (int n = 0; n < LANES; n++) begin
        out_data_d[LANE_W*n +: LANE_W] = sat_lane(acc_d[n]);
      end
    end
  end

  // State, counters, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      kx_q         <= '0;
      ky_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      in_addr_q    <= '0;
      w_tap_q      <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      rd_pend_q    <= 1'b0;
      first_pend_q <= 1'b0;
      for (int n = 0; n < LANES; n++) begin
        acc_q[n] <= '0;
      end
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      kx_q         <= kx_d;
      ky_q         <= ky_d;
      col_q        <= col_d;
      row_q        <= row_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      in_addr_q    <= in_addr_d;
      w_tap_q      <= w_tap_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      rd_pend_q    <= rd_en_q;
      first_pend_q <= (w_tap_q == 4'd0);
      for (int n = 0; n < LANES; n++) begin
        acc_q[n] <= acc_d[n];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.in_rd_en  = rd_en_q;
  assign bus.in_addr   = in_addr_q;
  assign bus.w_tap     = w_tap_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_layer1_conv_ctrl.sv
// Bench for layer1_conv_ctrl on a 4x4 image. A table of per-(address, tap, lane)
// products stands in for the datapath; expected output words are plain sums of
// the nine table entries of each 3x3 window, saturated to signed 16 bit.
module tb_layer1_conv_ctrl;
  localparam int W = 4;
  localparam int H = 4;
  localparam int OW = W - 2;
  localparam int OH = H - 2;
  localparam int NPIX = OW * OH;
  localparam int NTAP = 9;
  localparam int LANES = 8;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  layer1_conv_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  layer1_conv_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(ADDR_W), .ACC_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] prod [W*H][NTAP][LANES];

  int n_pass = 0;
  int n_total = 0;

  // Datapath stand-in: product for a read appears one cycle after the strobe.
  logic pv_rd = 1'b0;
  int   pv_addr = 0;
  int   pv_tap = 0;
  always @(negedge clk) begin
    logic [127:0] w;
    if (pv_rd && pv_addr < W*H && pv_tap < NTAP) begin
      for (int n = 0; n < LANES; n++) w[16*n +: 16] = prod[pv_addr][pv_tap][n];
    end else begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    bus.psum = w;
    pv_rd   = bus.in_rd_en;
    pv_addr = int'(bus.in_addr);
    pv_tap  = int'(bus.w_tap);
  end

  task automatic fill_table(input int mode);
    for (int a = 0; a < W*H; a++)
      for (int t = 0; t < NTAP; t++)
        for (int n = 0; n < LANES; n++)
          case (mode)
            0: prod[a][t][n] = 16'd3;
            1: prod[a][t][n] = 16'h7FFF;
            2: prod[a][t][n] = 16'h8000;
            3: prod[a][t][n] = 16'($urandom);
            default: prod[a][t][n] = 16'($urandom_range(1000)) - 16'd500;
          endcase
  endtask

  function automatic logic [127:0] exp_word(input int r, input int c);
    logic [127:0] w;
    longint s;
    w = '0;
    for (int n = 0; n < LANES; n++) begin
      s = 0;
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          s += longint'($signed(prod[(r+ky)*W + c + kx][ky*3 + kx][n]));
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`ifdef LAYER1_RELU_EN
      if (s < 0) s = 0;
`endif
      w[16*n +: 16] = 16'(s);
    end
    return w;
  endfunction

  function automatic int exp_rd_addr(input int k);
    int p, t;
    p = k / NTAP;
    t = k % NTAP;
    return ((p / OW) + t / 3) * W + (p % OW) + t % 3;
  endfunction

  // Observations collected by run_pass.
  logic [127:0] obs_data [$];
  int obs_addr [$];
  int rd_addr [$];
  int rd_tap [$];
  int busy_rise, done_at, done_cnt, proto_err, stab_err, stall_first;
  logic busy_at_done;
  bit timed_out;

  task automatic run_pass(input int stall_pct, input bit stall5, input bit poke_start);
    int cyc, hold_left, pa;
    bit stalled_once, pend;
    logic [127:0] pd;
    obs_data.delete(); obs_addr.delete(); rd_addr.delete(); rd_tap.delete();
    busy_rise = -1; done_at = -1; done_cnt = 0; proto_err = 0; stab_err = 0;
    stall_first = 0; busy_at_done = 1'b0; timed_out = 0;
    hold_left = 0; stalled_once = 0; pend = 0; pd = '0; pa = 0;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    forever begin
      if (bus.busy === 1'b1 && busy_rise < 0) busy_rise = cyc;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin done_at = cyc; busy_at_done = bus.busy; end
      end
      if (done_at >= 0 && cyc == done_at + 1 && (bus.busy !== 1'b0 || bus.done !== 1'b0)) proto_err++;
      if (bus.out_valid === 1'b1 && bus.in_rd_en !== 1'b0) proto_err++;
      if (bus.out_valid === 1'b1 && bus.busy !== 1'b1) proto_err++;
      if (bus.in_rd_en === 1'b1) begin
        rd_addr.push_back(int'(bus.in_addr));
        rd_tap.push_back(int'(bus.w_tap));
      end
      if (pend && (bus.out_valid !== 1'b1 || bus.out_data !== pd || int'(bus.out_addr) != pa)) stab_err++;
      if (stall5 && !stalled_once && bus.out_valid === 1'b1) begin
        hold_left = 5; stalled_once = 1;
      end
      if (hold_left > 0) begin
        bus.out_ready = 1'b0; hold_left--;
      end else begin
        bus.out_ready = (int'($urandom_range(99)) >= stall_pct);
      end
      pend = (bus.out_valid === 1'b1) && !bus.out_ready;
      if (pend) begin
        pd = bus.out_data; pa = int'(bus.out_addr);
        if (obs_data.size() == 0) stall_first++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        obs_data.push_back(bus.out_data);
        obs_addr.push_back(int'(bus.out_addr));
      end
      bus.start = (poke_start && (cyc == 17 || cyc == 21)) ? 1'b1 : 1'b0;
      if (done_at >= 0 && cyc >= done_at + 3) break;
      if (cyc >= 3000) begin timed_out = 1; break; end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_total++; if (bus.in_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.in_rd_en); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_addr !== '0) $display("FAIL reset_in_addr: got %h want 0", bus.in_addr); else n_pass++;
    n_total++; if (bus.w_tap !== 4'd0) $display("FAIL reset_w_tap: got %h want 0", bus.w_tap); else n_pass++;
    n_total++; if (bus.out_addr !== '0) $display("FAIL reset_out_addr: got %h want 0", bus.out_addr); else n_pass++;
    n_total++; if (bus.out_data !== '0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_no_start_busy: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_basic();
    int exp0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int bad;
    fill_table(0);
    run_pass(0, 0, 0);
    n_total++; if (done_at - busy_rise != 44) $display("FAIL basic_latency: got %0d want 44", done_at - busy_rise); else n_pass++;
    n_total++; if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (obs_data.size() != NPIX) $display("FAIL basic_word_count: got %0d want %0d", obs_data.size(), NPIX); else n_pass++;
    for (int i = 0; i < obs_data.size(); i++) begin
      n_total++; if (obs_data[i] !== {8{16'h001B}}) $display("FAIL basic_data[%0d]: got %h want %h", i, obs_data[i], {8{16'h001B}}); else n_pass++;
      n_total++; if (obs_addr[i] != i) $display("FAIL basic_addr[%0d]: got %0d want %0d", i, obs_addr[i], i); else n_pass++;
    end
    n_total++; if (rd_addr.size() != NPIX*NTAP) $display("FAIL basic_read_count: got %0d want %0d", rd_addr.size(), NPIX*NTAP); else n_pass++;
    if (rd_addr.size() >= NPIX*NTAP) begin
      bad = 0;
      for (int k = 0; k < 9; k++) if (rd_addr[k] != exp0[k]) bad++;
      n_total++; if (bad != 0) $display("FAIL pix0_addr_seq: got %0d wrong addresses want 0", bad); else n_pass++;
      bad = 0;
      for (int k = 0; k < 9; k++) if (rd_tap[k] != k) bad++;
      n_total++; if (bad != 0) $display("FAIL pix0_tap_seq: got %0d wrong taps want 0", bad); else n_pass++;
      n_total++; if (rd_addr[27] != 5) $display("FAIL pix3_start_addr: got %0d want 5", rd_addr[27]); else n_pass++;
    end
    n_total++; if (proto_err != 0) $display("FAIL basic_protocol: got %0d violations want 0", proto_err); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [127:0] want;
    for (int m = 1; m <= 2; m++) begin
      fill_table(m);
      want = {8{16'h7FFF}};
      if (m == 2) begin
`ifdef LAYER1_RELU_EN
        want = '0;
`else
        want = {8{16'h8000}};
`endif
      end
      run_pass(0, 0, 0);
      n_total++; if (obs_data.size() != NPIX) $display("FAIL sat%0d_word_count: got %0d want %0d", m, obs_data.size(), NPIX); else n_pass++;
      for (int i = 0; i < obs_data.size(); i++) begin
        n_total++; if (obs_data[i] !== want) $display("FAIL sat%0d_data[%0d]: got %h want %h", m, i, obs_data[i], want); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    fill_table(4);
    run_pass(0, 1, 0);
    n_total++; if (stall_first != 5) $display("FAIL bp_stall_cycles: got %0d want 5", stall_first); else n_pass++;
    n_total++; if (stab_err != 0) $display("FAIL bp_hold_stable: got %0d changes want 0", stab_err); else n_pass++;
    n_total++; if (proto_err != 0) $display("FAIL bp_protocol: got %0d violations want 0", proto_err); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL bp_done_count: got %0d want 1", done_cnt); else n_pass++;
    for (int i = 0; i < obs_data.size(); i++) begin
      n_total++; if (obs_data[i] !== exp_word(i / OW, i % OW)) $display("FAIL bp_data[%0d]: got %h want %h", i, obs_data[i], exp_word(i / OW, i % OW)); else n_pass++;
    end
  endtask

  task automatic test_random();
    int bad;
    for (int k = 0; k < 3; k++) begin
      fill_table((k % 2 == 0) ? 3 : 4);
      run_pass(35, 0, 0);
      n_total++; if (timed_out || done_cnt != 1) $display("FAIL rnd%0d_done: got count %0d timeout %0d want 1 0", k, done_cnt, timed_out); else n_pass++;
      n_total++; if (obs_data.size() != NPIX) $display("FAIL rnd%0d_word_count: got %0d want %0d", k, obs_data.size(), NPIX); else n_pass++;
      for (int i = 0; i < obs_data.size(); i++) begin
        n_total++; if (obs_data[i] !== exp_word(i / OW, i % OW) || obs_addr[i] != i)
          $display("FAIL rnd%0d_word[%0d]: got %h@%0d want %h@%0d", k, i, obs_data[i], obs_addr[i], exp_word(i / OW, i % OW), i);
        else n_pass++;
      end
      bad = (rd_addr.size() != NPIX*NTAP) ? 1 : 0;
      for (int j = 0; j < rd_addr.size() && j < NPIX*NTAP; j++)
        if (rd_addr[j] != exp_rd_addr(j) || rd_tap[j] != j % NTAP) bad++;
      n_total++; if (bad != 0) $display("FAIL rnd%0d_read_trace: got %0d errors want 0", k, bad); else n_pass++;
      n_total++; if (stab_err != 0 || proto_err != 0) $display("FAIL rnd%0d_protocol: got %0d/%0d want 0/0", k, stab_err, proto_err); else n_pass++;
    end
  endtask

  task automatic test_start_while_busy();
    fill_table(3);
    run_pass(0, 0, 1);
    n_total++; if (done_cnt != 1) $display("FAIL swb_done_count: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (done_at - busy_rise != 44) $display("FAIL swb_latency: got %0d want 44", done_at - busy_rise); else n_pass++;
    n_total++; if (rd_addr.size() != NPIX*NTAP) $display("FAIL swb_read_count: got %0d want %0d", rd_addr.size(), NPIX*NTAP); else n_pass++;
    for (int i = 0; i < obs_data.size(); i++) begin
      n_total++; if (obs_data[i] !== exp_word(i / OW, i % OW)) $display("FAIL swb_data[%0d]: got %h want %h", i, obs_data[i], exp_word(i / OW, i % OW)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int reads, cyc, bad;
    fill_table(4);
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reads = 0;
    cyc = 0;
    // Stop inside pixel 2's fetch (reads 18..26).
    while (reads < 20 && cyc < 200) begin
      if (bus.in_rd_en === 1'b1) reads++;
      if (reads < 20) begin @(negedge clk); cyc++; end
    end
    n_total++; if (reads != 20) $display("FAIL rmid_reach_fetch: got %0d reads want 20", reads); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if ({bus.busy, bus.done, bus.in_rd_en, bus.out_valid} !== 4'b0000)
      $display("FAIL rmid_ctrl_zero: got %b want 0000", {bus.busy, bus.done, bus.in_rd_en, bus.out_valid}); else n_pass++;
    n_total++; if (bus.in_addr !== '0 || bus.w_tap !== 4'd0 || bus.out_addr !== '0 || bus.out_data !== '0)
      $display("FAIL rmid_bus_zero: got %h %h %h %h want all 0", bus.in_addr, bus.w_tap, bus.out_addr, bus.out_data); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.in_rd_en !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL rmid_quiet_after: got %0d active cycles want 0", bad); else n_pass++;
    run_pass(20, 0, 0);
    n_total++; if (done_cnt != 1 || obs_data.size() != NPIX) $display("FAIL rmid_pass: got done %0d words %0d want 1 %0d", done_cnt, obs_data.size(), NPIX); else n_pass++;
    for (int i = 0; i < obs_data.size(); i++) begin
      n_total++; if (obs_data[i] !== exp_word(i / OW, i % OW) || obs_addr[i] != i)
        $display("FAIL rmid_word[%0d]: got %h@%0d want %h@%0d", i, obs_data[i], obs_addr[i], exp_word(i / OW, i % OW), i);
      else n_pass++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    bus.psum = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
